// File: rtl/gate_boy_pkg.sv
// Shared types and constants for the multi-cycle Game Boy ALU.
// F register layout is {Z,N,H,C,4'b0}; the low nibble always reads as zero.
package gate_boy_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int FLAG_WIDTH = 8;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_ADC,
        OP_SUB,
        OP_SBC,
        OP_AND,
        OP_XOR,
        OP_OR,
        OP_CP,
        OP_INC,
        OP_DEC,
        OP_DAA
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WIDE_HI,
        ST_DONE
    } alu_state_t;

    // Carry/borrow fed into the lowest slice: ADC/SBC chain the F register
    // carry, INC/DEC are modelled as +1/-1 through the carry input.
    function automatic logic first_cin(alu_op_t op, logic c_flag);
        case (op)
            OP_ADC, OP_SBC: first_cin = c_flag;
            OP_INC, OP_DEC: first_cin = 1'b1;
            default:        first_cin = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between decoder/register file and the ALU.
// master = requester (drives operands, consumes the result), slave = ALU.
interface alu_multicycle_if #(
    parameter int W = 16
);
    import gate_boy_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    alu_op_t               op;
    logic                  wide;
    logic [W-1:0]          operand_a;
    logic [W-1:0]          operand_b;
    logic [FLAG_WIDTH-1:0] flags_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          result;
    logic [FLAG_WIDTH-1:0] flags_out;
    logic                  busy;

    modport master (
        output in_valid, op, wide, operand_a, operand_b, flags_in, out_ready,
        input  in_ready, out_valid, result, flags_out, busy
    );

    modport slave (
        input  in_valid, op, wide, operand_a, operand_b, flags_in, out_ready,
        output in_ready, out_valid, result, flags_out, busy
    );

endinterface

// File: rtl/alu_multicycle_slice.sv
// alu_slice: combinational DATA_WIDTH-bit ALU slice with carry in/out and
// half-carry out. The top reuses one instance for every pass of a wide op.
module alu_slice
    import gate_boy_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int HALF_BIT   = 4
) (
    input  alu_op_t               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  cout,
    output logic                  hout
);

    logic [DATA_WIDTH-1:0] b_eff;
    logic [DATA_WIDTH:0]   sum;

    // INC/DEC ignore operand B; the +/-1 arrives through cin.
    assign b_eff = (op == OP_INC || op == OP_DEC) ? '0 : b;

    // Slice datapath: one DATA_WIDTH+1 bit add or subtract, or a bitwise op.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        sum  = '0;
        res  = a;
        cout = 1'b0;
        hout = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_INC: begin
                sum  = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, cin};
                res  = sum[DATA_WIDTH-1:0];
                cout = sum[DATA_WIDTH];
                // Carry into bit HALF_BIT recovered from the sum bit itself.
                hout = a[HALF_BIT] ^ b_eff[HALF_BIT] ^ sum[HALF_BIT];
            end
            OP_SUB, OP_SBC, OP_CP, OP_DEC: begin
                sum  = {1'b0, a} - {1'b0, b_eff} - {{DATA_WIDTH{1'b0}}, cin};
                res  = sum[DATA_WIDTH-1:0];
                cout = sum[DATA_WIDTH];
                hout = a[HALF_BIT] ^ b_eff[HALF_BIT] ^ sum[HALF_BIT];
            end
            OP_AND:  res = a & b;
            OP_XOR:  res = a ^ b;
            OP_OR:   res = a | b;
            default: res = a;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: Game Boy ALU executing narrow ops in one cycle and wide
// (WIDE_FACTOR*DATA_WIDTH) ops one slice per cycle through a shared alu_slice.
// Optional feature macro: ALU_DAA_EN (decimal adjust; DAA is a NOP without it).
module alu_multicycle
    import gate_boy_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int HALF_BIT    = 4,
    parameter int WIDE_FACTOR = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_multicycle_if.slave bus
);

    localparam int W     = WIDE_FACTOR * DATA_WIDTH;
    localparam int IDX_W = (WIDE_FACTOR > 1) ? $clog2(WIDE_FACTOR) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDE_FACTOR - 1);

    alu_state_t            state_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic [W-1:0]          result_q;
    logic [FLAG_WIDTH-1:0] flags_q;
    logic [W-1:0]          a_q;
    logic [W-1:0]          b_q;
    logic [W-1:0]          acc_q;
    logic [FLAG_WIDTH-1:0] fl_in_q;
    alu_op_t               op_q;
    logic                  carry_q;
    logic [IDX_W-1:0]      idx_q;

    alu_op_t               sl_op;
    logic [DATA_WIDTH-1:0] sl_a;
    logic [DATA_WIDTH-1:0] sl_b;
    logic [DATA_WIDTH-1:0] sl_res;
    logic                  sl_cin;
    logic                  sl_cout;
    logic                  sl_hout;

    logic                  accept;
    logic                  req_wide;
    alu_op_t               ctx_op;
    logic                  ctx_wide;
    logic [W-1:0]          ctx_a;
    logic [FLAG_WIDTH-1:0] ctx_flags;
    logic [W-1:0]          raw_d;
    logic                  z_all;
    logic [W-1:0]          result_d;
    logic [FLAG_WIDTH-1:0] flags_d;
    logic [7:0]            daa_res;
    logic [FLAG_WIDTH-1:0] daa_flags;

    assign bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags_out = flags_q;
    assign bus.busy      = busy_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign req_wide = bus.wide && (bus.op != OP_DAA);

    // Slice operands: the request bus on accept, the captured operands while chaining.
    always_comb begin
        if (state_q == ST_WIDE_HI) begin
            sl_op  = op_q;
            sl_a   = a_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
            sl_b   = b_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
            sl_cin = carry_q;
        end else begin
            sl_op  = bus.op;
            sl_a   = bus.operand_a[DATA_WIDTH-1:0];
            sl_b   = bus.operand_b[DATA_WIDTH-1:0];
            sl_cin = first_cin(bus.op, bus.flags_in[FLAG_C]);
        end
    end

    alu_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .HALF_BIT   (HALF_BIT)
    ) u_slice (
        .op   (sl_op),
        .a    (sl_a),
        .b    (sl_b),
        .cin  (sl_cin),
        .res  (sl_res),
        .cout (sl_cout),
        .hout (sl_hout)
    );

`ifdef ALU_DAA_EN
    // Decimal adjust of operand_a[7:0]; conditions use the unadjusted value.
    always_comb begin
        logic [7:0] adj;
        logic       c_new;
        adj   = 8'h00;
        c_new = bus.flags_in[FLAG_C];
        if (!bus.flags_in[FLAG_N]) begin
            if (bus.flags_in[FLAG_C] || bus.operand_a[7:0] > 8'h99) begin
                adj   = adj | 8'h60;
                c_new = 1'b1;
            end
            if (bus.flags_in[FLAG_H] || bus.operand_a[3:0] > 4'h9) begin
                adj = adj | 8'h06;
            end
            daa_res = bus.operand_a[7:0] + adj;
        end else begin
            if (bus.flags_in[FLAG_C]) adj = adj | 8'h60;
            if (bus.flags_in[FLAG_H]) adj = adj | 8'h06;
            daa_res = bus.operand_a[7:0] - adj;
        end
        daa_flags = {daa_res == 8'h00, bus.flags_in[FLAG_N], 1'b0, c_new, 4'b0000};
    end
`else
    // DAA disabled: pass operand_a and the F register straight through.
    always_comb begin
        daa_res   = bus.operand_a[7:0];
        daa_flags = bus.flags_in & 8'hF0;
    end
`endif

    // Result/flag formation for whichever slice is being computed this cycle.
    always_comb begin
        if (state_q == ST_WIDE_HI) begin
            ctx_op    = op_q;
            ctx_wide  = 1'b1;
            ctx_a     = a_q;
            ctx_flags = fl_in_q;
            raw_d     = acc_q;
            raw_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = sl_res;
        end else begin
            ctx_op    = bus.op;
            ctx_wide  = 1'b0;
            ctx_a     = {{(W-DATA_WIDTH){1'b0}}, bus.operand_a[DATA_WIDTH-1:0]};
            ctx_flags = bus.flags_in;
            raw_d     = {{(W-DATA_WIDTH){1'b0}}, sl_res};
        end

        z_all    = (raw_d == '0);
        result_d = raw_d;
        flags_d  = '0;
        case (ctx_op)
            OP_ADD: begin
                flags_d[FLAG_Z] = ctx_wide ? ctx_flags[FLAG_Z] : z_all;
                flags_d[FLAG_H] = sl_hout;
                flags_d[FLAG_C] = sl_cout;
            end
            OP_ADC: begin
                flags_d[FLAG_Z] = z_all;
                flags_d[FLAG_H] = sl_hout;
                flags_d[FLAG_C] = sl_cout;
            end
            OP_SUB, OP_SBC, OP_CP: begin
                flags_d[FLAG_Z] = z_all;
                flags_d[FLAG_N] = 1'b1;
                flags_d[FLAG_H] = sl_hout;
                flags_d[FLAG_C] = sl_cout;
                // CP only compares: flags from the difference, result is A.
                if (ctx_op == OP_CP) result_d = ctx_a;
            end
            OP_AND: begin
                flags_d[FLAG_Z] = z_all;
                flags_d[FLAG_H] = 1'b1;
            end
            OP_XOR, OP_OR: begin
                flags_d[FLAG_Z] = z_all;
            end
            OP_INC, OP_DEC: begin
                if (ctx_wide) begin
                    flags_d = ctx_flags & 8'hF0;
                end else begin
                    flags_d[FLAG_Z] = z_all;
                    flags_d[FLAG_N] = (ctx_op == OP_DEC);
                    flags_d[FLAG_H] = sl_hout;
                    flags_d[FLAG_C] = ctx_flags[FLAG_C];
                end
            end
            OP_DAA: begin
                result_d = {{(W-8){1'b0}}, daa_res};
                flags_d  = daa_flags;
            end
            default: ;
        endcase
    end

    // Control FSM with registered outputs; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            fl_in_q     <= '0;
            op_q        <= OP_ADD;
            carry_q     <= 1'b0;
            idx_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (req_wide) begin
                            state_q     <= ST_WIDE_HI;
                            out_valid_q <= 1'b0;
                            acc_q       <= raw_d;
                            carry_q     <= sl_cout;
                            a_q         <= bus.operand_a;
                            b_q         <= bus.operand_b;
                            op_q        <= bus.op;
                            fl_in_q     <= bus.flags_in;
                            idx_q       <= IDX_W'(1);
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= result_d;
                            flags_q     <= flags_d;
                        end
                    end else if (state_q == ST_DONE && bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                ST_WIDE_HI: begin
                    if (idx_q == LAST_IDX) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= result_d;
                        flags_q     <= flags_d;
                    end else begin
                        acc_q   <= raw_d;
                        carry_q <= sl_cout;
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: a reference model pushes expected
// results on accept, a negedge monitor pops and compares on each handshake.
module tb_alu_multicycle;
    import gate_boy_pkg::*;

    localparam int DW = 8;
    localparam int WF = 2;
    localparam int W  = DW * WF;

    typedef struct {
        string       tag;
        logic [15:0] result;
        logic [7:0]  flags;
        int          acc_cyc;
        int          lat;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_extra = 0;
    int   cyc     = 0;
    bit   lat_mode;
    bit   stop_rand;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_multicycle_if #(.W(W)) bus ();

    alu_multicycle #(
        .DATA_WIDTH  (DW),
        .HALF_BIT    (4),
        .WIDE_FACTOR (WF)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference model written directly from the instruction definitions.
    function automatic exp_t model(alu_op_t op, logic w_in, logic [15:0] a, logic [15:0] b,
                                   logic [7:0] f);
        exp_t e;
        bit   w, z, n, h, c;
        int   mask, hs, aa, bb, ci, cih, r, res;
        w    = w_in && (op != OP_DAA);
        mask = w ? 'hFFFF : 'hFF;
        hs   = w ? 8 : 0;
        aa   = int'(a) & mask;
        bb   = int'(b) & mask;
        ci   = (op == OP_ADC || op == OP_SBC) ? int'(f[4]) : 0;
        z = 0; n = 0; h = 0; c = 0; res = 0;
        e.flags = 8'h00;
        case (op)
            OP_ADD, OP_ADC: begin
                r   = aa + bb + ci;
                res = r & mask;
                cih = w ? int'(((aa & 255) + (bb & 255) + ci) > 255) : ci;
                h   = (((aa >> hs) & 15) + ((bb >> hs) & 15) + cih) > 15;
                c   = r > mask;
                z   = (op == OP_ADD && w) ? f[7] : (res == 0);
            end
            OP_SUB, OP_SBC, OP_CP: begin
                r   = aa - bb - ci;
                cih = w ? int'(((aa & 255) - (bb & 255) - ci) < 0) : ci;
                h   = (((aa >> hs) & 15) - ((bb >> hs) & 15) - cih) < 0;
                c   = r < 0;
                z   = (r & mask) == 0;
                n   = 1;
                res = (op == OP_CP) ? aa : (r & mask);
            end
            OP_AND: begin res = aa & bb; z = res == 0; h = 1; end
            OP_XOR: begin res = aa ^ bb; z = res == 0; end
            OP_OR:  begin res = aa | bb; z = res == 0; end
            OP_INC, OP_DEC: begin
                res = ((op == OP_INC) ? aa + 1 : aa - 1) & mask;
                z   = res == 0;
                n   = (op == OP_DEC);
                h   = (op == OP_INC) ? ((aa & 15) == 15) : ((aa & 15) == 0);
                c   = f[4];
                if (w) begin z = f[7]; n = f[6]; h = f[5]; end
            end
            default: begin
`ifdef ALU_DAA_EN
                int adj;
                adj = 0;
                c   = f[4];
                if (!f[6]) begin
                    if (f[4] || aa > 'h99) begin adj += 'h60; c = 1; end
                    if (f[5] || (aa & 15) > 9) adj += 'h06;
                    res = (aa + adj) & 255;
                end else begin
                    if (f[4]) adj += 'h60;
                    if (f[5]) adj += 'h06;
                    res = (aa - adj) & 255;
                end
                z = res == 0;
                n = f[6];
                h = 0;
`else
                res = aa & 255;
                z = f[7]; n = f[6]; h = f[5]; c = f[4];
`endif
            end
        endcase
        e.result  = 16'(res);
        e.flags   = {z, n, h, c, 4'b0000};
        e.lat     = w ? 2 : 1;
        e.chk_lat = 0;
        e.acc_cyc = 0;
        e.tag     = "";
        return e;
    endfunction

    // Drive one request (called just after a rising edge) and log it on accept.
    task automatic send(string tag, alu_op_t op, logic w, logic [15:0] a, logic [15:0] b,
                        logic [7:0] f, output int waits);
        exp_t e;
        bit   done;
        e = model(op, w, a, b, f);
        e.tag     = tag;
        e.chk_lat = lat_mode;
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.wide      = w;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.flags_in  = f;
        waits = 0;
        done  = 0;
        while (!done && waits < 50) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.acc_cyc = cyc;
                sb.push_back(e);
                done = 1;
            end else begin
                waits++;
            end
        end
        if (!done) check({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: compare every consumed result against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_extra++;
            end else begin
                e = sb.pop_front();
                check({e.tag, "_result"}, 32'(bus.result), 32'(e.result));
                check({e.tag, "_flags"}, 32'(bus.flags_out), 32'(e.flags));
                if (e.chk_lat) check({e.tag, "_latency"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waits;
        logic [15:0] ra, rb;
        logic [7:0]  rf;
        exp_t        hold;

        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.wide      = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.flags_in  = '0;
        bus.out_ready = 1'b1;
        lat_mode      = 1'b1;
        stop_rand     = 1'b0;
        rst_n         = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    32'(bus.result),    32'd0);
        check("rst_flags",     32'(bus.flags_out), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, issued back to back with out_ready held high.
        send("add",      OP_ADD, 1'b0, 16'h003A, 16'h00C6, 8'h00, waits);
        send("sub",      OP_SUB, 1'b0, 16'h003E, 16'h003E, 8'h00, waits);
        send("cp",       OP_CP,  1'b0, 16'h003E, 16'h003E, 8'h00, waits);
        send("wadd",     OP_ADD, 1'b1, 16'h8A23, 16'h0605, 8'h80, waits);
        send("inc",      OP_INC, 1'b0, 16'h000F, 16'h0000, 8'h10, waits);
        send("wdec",     OP_DEC, 1'b1, 16'h0000, 16'h0000, 8'h50, waits);
        send("daa",      OP_DAA, 1'b0, 16'h007D, 16'h0000, 8'h00, waits);
        send("wdaa",     OP_DAA, 1'b1, 16'h127D, 16'h0000, 8'h00, waits);
        send("nadd_hi",  OP_ADD, 1'b0, 16'hFF3A, 16'h12C6, 8'h00, waits);
        send("winc_wrap",OP_INC, 1'b1, 16'hFFFF, 16'h0000, 8'hA0, waits);
        send("and",      OP_AND, 1'b0, 16'h00F0, 16'h000F, 8'h10, waits);
        send("wsbc",     OP_SBC, 1'b1, 16'h1000, 16'h0001, 8'h10, waits);
        send("adc",      OP_ADC, 1'b0, 16'h00FF, 16'h0000, 8'h10, waits);
        send("wcp",      OP_CP,  1'b1, 16'h1234, 16'h1234, 8'h00, waits);
        drain("directed");

        // Backpressure: result must hold while out_ready is low.
        lat_mode      = 1'b0;
        bus.out_ready = 1'b0;
        hold = model(OP_XOR, 1'b0, 16'h0055, 16'h000F, 8'h00);
        send("bp_xor", OP_XOR, 1'b0, 16'h0055, 16'h000F, 8'h00, waits);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result",    32'(bus.result),    32'(hold.result));
            check("bp_flags",     32'(bus.flags_out), 32'(hold.flags));
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send("bb_or", OP_OR, 1'b0, 16'h0050, 16'h0005, 8'h00, waits);
        check("bb_accept_wait", 32'(waits), 32'd0);
        drain("bp");

        // Reset while the high slice is pending: nothing may ever be presented.
        lat_mode = 1'b1;
        send("rst_wadd", OP_ADD, 1'b1, 16'h1234, 16'h1111, 8'h00, waits);
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_busy",     32'(bus.busy),     32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random mix with random backpressure.
        lat_mode = 1'b0;
        fork
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rf = {4'($urandom_range(0, 15)), 4'b0000};
            send("rnd", alu_op_t'(4'($urandom_range(0, 10))), 1'($urandom_range(0, 1)),
                 ra, rb, rf, waits);
        end
        stop_rand = 1'b1;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain("rnd");

        check("extra_outputs", 32'(n_extra), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
